envelope_vca: RTL

//  ADSR envelope generator plus voltage-controlled amplifier for one voice.

---
 rtl/envelope_vca.sv | 118 +++++++++++
 1 files changed

// File: rtl/envelope_vca.sv
// rtl/envelope_vca.sv - ADSR envelope generator with a registered VCA for one voice
module envelope_vca #(
  parameter int WAVE_DEPTH = 8,
  parameter int FRAC_BITS  = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  gate_open_i,
  input  logic                  gate_close_i,
  input  logic [WAVE_DEPTH-1:0] attack_i,
  input  logic [WAVE_DEPTH-1:0] decay_i,
  input  logic [WAVE_DEPTH-1:0] sustain_i,
  input  logic [WAVE_DEPTH-1:0] release_i,
  input  logic [WAVE_DEPTH-1:0] waveform_i,
  output logic [WAVE_DEPTH-1:0] envelope_o,
  output logic [2:0]            stage_o,
  output logic                  active_o,
  output logic [WAVE_DEPTH-1:0] wave_out_o
);

  localparam int W = WAVE_DEPTH + FRAC_BITS;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } stage_e;

  stage_e                    stage_q, stage_d;
  logic [W-1:0]              acc_q, acc_d;
  logic [WAVE_DEPTH-1:0]     wave_out_q, wave_out_d;
  logic [W-1:0]              sus_lvl;
  logic [W:0]                acc_ext, max_ext, sus_ext;
  logic [W:0]                att_ext, dec_ext, rel_ext;
  logic [W:0]                att_sum, dec_diff;
  logic [2*WAVE_DEPTH-1:0]   product;

  // Rates and levels widened by one bit so sums and differences never wrap
  assign sus_lvl  = {sustain_i, {FRAC_BITS{1'b0}}};
  assign acc_ext  = {1'b0, acc_q};
  assign max_ext  = {1'b0, {W{1'b1}}};
  assign sus_ext  = {1'b0, sus_lvl};
  assign att_ext  = {{(FRAC_BITS+1){1'b0}}, attack_i};
  assign dec_ext  = {{(FRAC_BITS+1){1'b0}}, decay_i};
  assign rel_ext  = {{(FRAC_BITS+1){1'b0}}, release_i};
  assign att_sum  = acc_ext + att_ext;
  assign dec_diff = acc_ext - dec_ext;

  // Gate events take priority and hold acc for a cycle; otherwise step the current stage
  always_comb begin
    stage_d = stage_q;
    acc_d   = acc_q;
    if (gate_open_i) begin
      stage_d = ST_ATTACK;
    end else if (gate_close_i &&
                 (stage_q == ST_ATTACK || stage_q == ST_DECAY || stage_q == ST_SUSTAIN)) begin
      stage_d = ST_RELEASE;
    end else begin
      case (stage_q)
        ST_ATTACK: begin
          if (attack_i == '0 || att_sum >= max_ext) begin
            acc_d   = '1;
            stage_d = ST_DECAY;
          end else begin
            acc_d = att_sum[W-1:0];
          end
        end
        ST_DECAY: begin
          if (decay_i == '0 || $signed(dec_diff) <= $signed(sus_ext)) begin
            acc_d   = sus_lvl;
            stage_d = ST_SUSTAIN;
          end else begin
            acc_d = dec_diff[W-1:0];
          end
        end
        ST_SUSTAIN: acc_d = sus_lvl;
        ST_RELEASE: begin
          if (release_i == '0 || acc_ext <= rel_ext) begin
            acc_d   = '0;
            stage_d = ST_IDLE;
          end else begin
            acc_d = acc_q - {{FRAC_BITS{1'b0}}, release_i};
          end
        end
        ST_IDLE: acc_d = '0;
        default: begin
          acc_d   = '0;
          stage_d = ST_IDLE;
        end
      endcase
    end
  end

  // VCA: upper half of the full product, so max envelope never overflows
  assign product    = {{WAVE_DEPTH{1'b0}}, waveform_i} * {{WAVE_DEPTH{1'b0}}, envelope_o};
  assign wave_out_d = WAVE_DEPTH'(product >> WAVE_DEPTH);

  // State, accumulator and output sample registers
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      stage_q    <= ST_IDLE;
      acc_q      <= '0;
      wave_out_q <= '0;
    end else begin
      stage_q    <= stage_d;
      acc_q      <= acc_d;
      wave_out_q <= wave_out_d;
    end
  end

  assign envelope_o = acc_q[W-1:FRAC_BITS];
  assign stage_o    = stage_q;
  assign active_o   = (stage_q != ST_IDLE);
  assign wave_out_o = wave_out_q;

endmodule
